// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared constants and FSM encoding for the instruction-memory loader
package im_loader_pkg;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam int          IM_IDX_W = 12;
    localparam int          IM_CNT_W = IM_IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/im_loader_word_packer.sv
// word_packer: assembles four big-endian bytes into a registered 32-bit word with a one-cycle full pulse
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o,
    output logic        full_o
);
    logic [23:0] part_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic        full_q;

    // shift bytes in MSB-first; the fourth byte publishes the word and pulses full
    always_ff @(posedge clk) begin
        if (!reset) begin
            part_q <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            full_q <= en_i && !clr_i && cnt_q == 2'd3;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i) begin
                part_q <= {part_q[15:0], byte_i};
                cnt_q  <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) word_q <= {part_q, byte_i};
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = word_q;
    assign full_o = full_q;
endmodule

// File: rtl/im_loader.sv
// im_loader: streams bytes into consecutive instruction-memory words while stalling the CPU
module im_loader
    import im_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [IM_CNT_W-1:0] word_cnt,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                im_we,
    output logic [31:0]         im_addr,
    output logic [31:0]         im_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done
);
    state_e              state_q, state_d;
    logic [IM_CNT_W-1:0] total_q, total_d;
    logic [IM_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]         addr_q, addr_d;
    logic                ready_q, hold_q, done_q;
    logic                accept, pk_clr, word_end;
    logic [1:0]          pk_cnt;

    assign accept   = state_q == S_LOAD && in_valid && !abort;
    assign pk_clr   = state_q != S_LOAD || abort;
    assign word_end = accept && pk_cnt == 2'd3;

    word_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (pk_clr),
        .en_i   (accept),
        .byte_i (in_data),
        .cnt_o  (pk_cnt),
        .word_o (im_wdata),
        .full_o (im_we)
    );

    // next state, latched count, word index and write address
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: if (start) begin
                total_d = word_cnt > IM_CNT_W'(IM_WORDS) ? IM_CNT_W'(IM_WORDS) : word_cnt;
                idx_d   = '0;
                state_d = word_cnt == '0 ? S_DONE : S_LOAD;
            end
            S_LOAD: if (abort) begin
                state_d = S_IDLE;
            end else if (word_end) begin
                addr_d = IM_BASE + 32'({idx_q, 2'b00});
                idx_d  = idx_q + IM_IDX_W'(1);
                if (IM_CNT_W'(idx_q) + IM_CNT_W'(1) == total_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered status outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            total_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            ready_q <= state_d == S_LOAD;
            hold_q  <= state_d != S_IDLE;
            done_q  <= state_d == S_DONE;
        end
    end

    assign in_ready = ready_q;
    assign im_addr  = addr_q;
    assign cpu_hold = hold_q;
    assign busy     = hold_q;
    assign done     = done_q;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized and directed checks of im_loader against a byte-queue reference model
module tb_im_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] word_cnt = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, im_we, cpu_hold, busy, done;
    logic [31:0] im_addr, im_wdata;

    int checks = 0;
    int errors = 0;
    int n_we, n_hold, n_done, n_dw;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    bit          loading, finishing, e_we;
    logic [7:0]  bytes[$];
    int          total, written;
    logic [31:0] e_addr, e_wdata;

    always #5 clk = ~clk;

    im_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .word_cnt (word_cnt),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: a load is a queue of accepted bytes; every fourth byte becomes one write
    task automatic model_edge();
        e_we = 1'b0;
        if (!reset) begin
            loading = 0; finishing = 0; bytes.delete();
            e_addr = '0; e_wdata = '0; total = 0; written = 0;
        end else if (finishing) begin
            finishing = 0;
        end else if (loading) begin
            if (abort) begin
                loading = 0;
                bytes.delete();
            end else if (in_valid) begin
                bytes.push_back(in_data);
                if (bytes.size() == 4) begin
                    e_wdata = {bytes[0], bytes[1], bytes[2], bytes[3]};
                    e_addr  = 32'h3000 + 32'(4 * written);
                    e_we    = 1'b1;
                    written++;
                    bytes.delete();
                    if (written == total) begin
                        loading = 0;
                        finishing = 1;
                    end
                end
            end
        end else if (start) begin
            total = word_cnt > 4096 ? 4096 : int'(word_cnt);
            written = 0;
            bytes.delete();
            if (total == 0) finishing = 1; else loading = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("in_ready", in_ready, loading);
        chk("im_we", im_we, e_we);
        chk("im_addr", im_addr, e_addr);
        chk("im_wdata", im_wdata, e_wdata);
        chk("cpu_hold", cpu_hold, loading | finishing);
        chk("busy", busy, loading | finishing);
        chk("done", done, finishing);
        if (im_we) begin
            n_we++;
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
        if (im_we && done) n_dw++;
        n_hold += int'(cpu_hold);
        n_done += int'(done);
    endtask

    task automatic clear_counts();
        n_we = 0; n_hold = 0; n_done = 0; n_dw = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic go(input int wc);
        word_cnt = 13'(wc);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [8] = '{8'h24, 8'h02, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};
        logic [7:0] rb [4];

        clear_counts();
        step();
        step();
        chk("rst_outs", {in_ready, im_we, cpu_hold, busy, done}, 0);
        reset = 1'b1;
        step();

        // two-word normal load
        clear_counts();
        go(2);
        for (int i = 0; i < 8; i++) begin
            in_data = seq[i]; in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("norm_writes", n_we, 2);
        if (n_we == 2) begin
            chk("norm_a0", wr_addr[0], 32'h3000);
            chk("norm_d0", wr_data[0], 32'h24020005);
            chk("norm_a1", wr_addr[1], 32'h3004);
            chk("norm_d1", wr_data[1], 32'hAC020000);
        end
        chk("norm_hold9", n_hold, 9);
        chk("norm_done_we", n_dw, 1);

        // gapped stream
        clear_counts();
        go(1);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0); in_data = 8'($urandom); step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("gap_writes", n_we, 1);
        chk("gap_done", n_done, 1);

        // zero count
        clear_counts();
        go(0);
        chk("zero_done", done, 1);
        step(); step();
        chk("zero_writes", n_we, 0);

        // abort on the sixth byte
        clear_counts();
        go(4);
        for (int i = 0; i < 5; i++) feed(8'($urandom));
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        step();
        abort = 1'b0;
        chk("abort_hold", cpu_hold, 0);
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        step();
        chk("abort_writes", n_we, 1);
        chk("abort_done", n_done, 0);

        // reset mid-load then reload
        clear_counts();
        go(2);
        for (int i = 0; i < 3; i++) feed(8'($urandom));
        reset = 1'b0; in_valid = 1'b1;
        step();
        chk("mid_rst_outs", {in_ready, im_we, cpu_hold, busy, done}, 0);
        chk("mid_rst_addr", im_addr, 0);
        chk("mid_rst_data", im_wdata, 0);
        reset = 1'b1; in_valid = 1'b0;
        step();
        clear_counts();
        go(1);
        for (int i = 0; i < 4; i++) begin
            rb[i] = 8'($urandom);
            feed(rb[i]);
        end
        step();
        chk("reload_writes", n_we, 1);
        if (n_we == 1) begin
            chk("reload_addr", wr_addr[0], 32'h3000);
            chk("reload_data", wr_data[0], {rb[0], rb[1], rb[2], rb[3]});
        end

        // start pulses during a load are ignored
        clear_counts();
        go(3);
        for (int i = 0; i < 12; i++) begin
            start = (i == 2 || i == 7);
            word_cnt = 13'd1;
            feed(8'($urandom));
        end
        start = 1'b0;
        step(); step();
        chk("restart_writes", n_we, 3);
        if (n_we == 3) chk("restart_a2", wr_addr[2], 32'h3008);

        // clamp to 4096 words
        clear_counts();
        go(5000);
        in_valid = 1'b1;
        for (int i = 0; i < 4096 * 4 + 4; i++) begin
            in_data = 8'($urandom); step();
        end
        in_valid = 1'b0;
        step();
        chk("clamp_writes", n_we, 4096);
        if (n_we > 0) chk("clamp_last", wr_addr[n_we - 1], 32'h6FFC);
        chk("clamp_done", n_done, 1);

        // random transactions with gaps, aborts and stray starts
        for (int t = 0; t < 30; t++) begin
            go($urandom_range(0, 6));
            for (int c = 0; c < 40; c++) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = 8'($urandom);
                abort    = ($urandom % 50) == 0;
                start    = ($urandom % 20) == 0;
                word_cnt = 13'($urandom_range(0, 6));
                step();
            end
            in_valid = 1'b0; abort = 1'b0; start = 1'b0;
            step(); step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-002 Port list SHALL be, clock and reset first (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; 0 = reset
- start  input  1  one-cycle pulse that begins a load
- abort  input  1  cancels an in-progress load
- word_cnt  input  13  number of 32-bit words to load, sampled on start
- in_data  input  8  instruction byte stream
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- im_we  output  1  instruction-memory write strobe, one cycle per word
- im_addr  output  32  byte address of the word being written
- im_wdata  output  32  assembled instruction word
- cpu_hold  output  1  stall request to the fetch unit while loading
- busy  output  1  high in LOAD or DONE
- done  output  1  one-cycle pulse when a load completes normally
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-005 In IDLE, start=1 SHALL latch min(word_cnt, 4096), clear the word index and byte count, and move to LOAD. If word_cnt=0, it SHALL instead move directly to DONE.
REQ-006 start SHALL be ignored in LOAD and in DONE.
REQ-007 in_ready SHALL be 1 only in LOAD. A byte is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-008 Bytes SHALL be packed big-endian: the first accepted byte goes to [31:24] and the fourth to [7:0].
REQ-009 On the edge that accepts the 4th byte of a word, the block SHALL register im_wdata and im_addr and set im_we=1 for exactly the following cycle.
REQ-010 im_addr SHALL equal 32'h0000_3000 + 4*index, with a 12-bit index. The range is therefore 0x3000..0x6FFC.
REQ-011 Acceptance SHALL continue without bubbles: a byte MAY be accepted in the same cycle that im_we=1.
REQ-012 On the edge that accepts the last byte of the last word, the FSM SHALL move to DONE. DONE SHALL last one cycle with done=1, coincident with the final im_we=1, and SHALL then return to IDLE.
REQ-013 cpu_hold and busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive, and 0 in IDLE.
REQ-014 abort=1 in LOAD SHALL take priority over byte acceptance on the same edge. The next cycle SHALL be IDLE, with im_we=0, done=0, and the partial word discarded. abort SHALL be ignored in IDLE and DONE.
REQ-015 in_valid gaps SHALL stall packing without losing the partial word.
REQ-016 Bytes offered while in_ready=0 SHALL NOT be consumed.

Reset
REQ-017 reset=0 SHALL force state=IDLE and clear the index, byte count and latched count. It SHALL also drive in_ready, im_we, cpu_hold, busy and done to 0, and im_addr and im_wdata to 32'h0, on the next edge.
REQ-018 Reset during LOAD SHALL discard any partial word. No im_we SHALL follow.

Structure
REQ-019 A shared package SHALL hold: IM_BASE=32'h0000_3000, IM_WORDS=4096, IM_IDX_W=12, and the FSM state encoding.
REQ-020 Byte-to-word assembly SHALL live in one sub-module, word_packer (byte in, 2-bit count, 32-bit word out, full flag).
REQ-021 The target RTL size SHALL be about 150-250 lines.

Verification
REQ-022 Normal load: word_cnt=2, bytes 24 02 00 05 AC 02 00 00 with in_valid held high -> im_we at 0x3000 with 0x24020005, then at 0x3004 with 0xAC020000; done=1 coincident with the second im_we; cpu_hold high for 9 cycles.
REQ-023 Gapped stream: word_cnt=1, in_valid toggled 1,0,1,0,... -> a single write of the correct word; no write before the 4th accepted byte.
REQ-024 Zero and clamp: word_cnt=0 -> done the cycle after start with no im_we. word_cnt=5000 -> exactly 4096 writes, the last at 0x6FFC.
REQ-025 Abort: word_cnt=4, abort asserted on the edge accepting byte 6 -> exactly 1 write, done never asserted, cpu_hold=0 on the next cycle.
REQ-026 Reset mid-load: reset=0 after 3 bytes -> all outputs 0 next cycle. A subsequent start with word_cnt=1 loads correctly at 0x3000.
REQ-027 start asserted during LOAD -> no effect on the index, count or addresses.
